// File: rtl/decode_ctrl_stage.sv
// Registered RV32I ID-stage control decoder with load-use interlock, flush and illegal-opcode flag.
// Optional M-extension decode is enabled by defining DECODE_MULDIV_EN.
module decode_ctrl_stage #(
    parameter int XLEN              = 32,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [1:0]      out_rs1_sel,
    output logic [1:0]      out_rs2_sel,
    output logic [1:0]      out_wb_sel,
    output logic [2:0]      out_func3,
    output logic [0:0]      out_func1,
    output logic [2:0]      out_func_mem,
    output logic            out_reg_write,
    output logic            out_is_branch,
    output logic            out_is_jal,
    output logic            out_is_jalr,
    output logic            out_is_load,
    output logic            out_is_store,
    output logic            out_illegal,
    output logic            out_muldiv
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [1:0] rs1_sel;
        logic [1:0] rs2_sel;
        logic [1:0] wb_sel;
        logic [2:0] func3;
        logic       func1;
        logic [2:0] func_mem;
        logic       reg_write;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic       is_load;
        logic       is_store;
        logic       illegal;
        logic       muldiv;
    } ctrl_t;

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_STALL = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [4:0]      ld_rd_q, ld_rd_d;
    logic            out_valid_q, out_valid_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic [XLEN-1:0] pc_q, pc_d;

    ctrl_t      dec_s;
    logic       use_rs1_s;
    logic       use_rs2_s;
    logic       hazard_s;
    logic       issue_s;
    logic       accept_s;
    logic [6:0] opcode_s;
    logic [2:0] f3_s;
    logic       is_m_s;

    assign opcode_s = in_instr[6:0];
    assign f3_s     = in_instr[14:12];
    assign is_m_s   = (in_instr[31:25] == 7'b0000001);

    // Opcode decode into the control word and register-use flags.
    always_comb begin
        dec_s     = '0;
        use_rs1_s = 1'b0;
        use_rs2_s = 1'b0;
        dec_s.rs1 = in_instr[19:15];
        dec_s.rs2 = in_instr[24:20];
        dec_s.rd  = in_instr[11:7];
        case (opcode_s)
            OP_LUI: begin
                dec_s.wb_sel    = 2'b11;
                dec_s.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                dec_s.rs1_sel   = 2'b00;
                dec_s.wb_sel    = 2'b01;
                dec_s.reg_write = 1'b1;
            end
            OP_JAL: begin
                dec_s.is_jal    = 1'b1;
                dec_s.wb_sel    = 2'b00;
                dec_s.reg_write = 1'b1;
            end
            OP_JALR: begin
                dec_s.is_jalr   = 1'b1;
                dec_s.rs1_sel   = 2'b01;
                dec_s.rs2_sel   = 2'b10;
                dec_s.wb_sel    = 2'b00;
                dec_s.reg_write = 1'b1;
                use_rs1_s       = 1'b1;
            end
            OP_BRANCH: begin
                dec_s.is_branch = 1'b1;
                dec_s.func3     = f3_s;
                use_rs1_s       = 1'b1;
                use_rs2_s       = 1'b1;
            end
            OP_STORE: begin
                dec_s.is_store  = 1'b1;
                dec_s.rs1_sel   = 2'b01;
                dec_s.rs2_sel   = 2'b01;
                dec_s.func_mem  = f3_s;
                use_rs1_s       = 1'b1;
                use_rs2_s       = 1'b1;
            end
            OP_LOAD: begin
                dec_s.is_load   = 1'b1;
                dec_s.rs1_sel   = 2'b01;
                dec_s.rs2_sel   = 2'b10;
                dec_s.wb_sel    = 2'b10;
                dec_s.func_mem  = f3_s;
                dec_s.reg_write = 1'b1;
                use_rs1_s       = 1'b1;
            end
            OP_R: begin
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
                if (is_m_s) begin
`ifdef DECODE_MULDIV_EN
                    dec_s.muldiv    = 1'b1;
                    dec_s.rs1_sel   = 2'b01;
                    dec_s.rs2_sel   = 2'b11;
                    dec_s.func3     = f3_s;
                    dec_s.wb_sel    = 2'b01;
                    dec_s.reg_write = 1'b1;
`else
                    dec_s.illegal   = 1'b1;
`endif
                end else begin
                    dec_s.rs1_sel   = 2'b01;
                    dec_s.rs2_sel   = 2'b11;
                    dec_s.func3     = f3_s;
                    dec_s.func1     = in_instr[30];
                    dec_s.wb_sel    = 2'b01;
                    dec_s.reg_write = 1'b1;
                end
            end
            OP_I: begin
                dec_s.rs1_sel   = 2'b01;
                dec_s.rs2_sel   = 2'b10;
                dec_s.func3     = f3_s;
                dec_s.func1     = (f3_s == 3'b101) ? in_instr[30] : 1'b0;
                dec_s.wb_sel    = 2'b01;
                dec_s.reg_write = 1'b1;
                use_rs1_s       = 1'b1;
            end
            default: begin
                dec_s.illegal = 1'b1;
            end
        endcase
        if (dec_s.rd == 5'd0) begin
            dec_s.reg_write = 1'b0;
        end else begin
            dec_s.reg_write = dec_s.reg_write;
        end
    end

    // Load-use hazard only bites while a load's result is still in flight.
    assign hazard_s = (state_q == ST_STALL) && in_valid &&
                      ((use_rs1_s && (dec_s.rs1 == ld_rd_q)) ||
                       (use_rs2_s && (dec_s.rs2 == ld_rd_q)));

    assign in_ready = !rst && !flush && !hazard_s && (!out_valid_q || out_ready);
    assign issue_s  = out_valid_q && out_ready;
    assign accept_s = in_valid && in_ready;

    // Next-state for the interlock FSM and the output word register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ld_rd_d     = ld_rd_q;
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        pc_d        = pc_q;
        if (flush) begin
            state_d     = ST_RUN;
            cnt_d       = 2'd0;
            out_valid_d = 1'b0;
        end else begin
            if (issue_s && ctrl_q.is_load && (ctrl_q.rd != 5'd0)) begin
                state_d = ST_STALL;
                cnt_d   = 2'(LOAD_STALL_CYCLES);
                ld_rd_d = ctrl_q.rd;
            end else if (state_q == ST_STALL) begin
                if (cnt_q <= 2'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = 2'd0;
                end else begin
                    state_d = ST_STALL;
                    cnt_d   = cnt_q - 2'd1;
                end
            end else begin
                state_d = ST_RUN;
            end
            if (accept_s) begin
                out_valid_d = 1'b1;
                ctrl_d      = dec_s;
                pc_d        = in_pc;
            end else if (issue_s) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= 2'd0;
            ld_rd_q     <= 5'd0;
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            pc_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ld_rd_q     <= ld_rd_d;
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            pc_q        <= pc_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_pc        = pc_q;
    assign out_rs1       = ctrl_q.rs1;
    assign out_rs2       = ctrl_q.rs2;
    assign out_rd        = ctrl_q.rd;
    assign out_rs1_sel   = ctrl_q.rs1_sel;
    assign out_rs2_sel   = ctrl_q.rs2_sel;
    assign out_wb_sel    = ctrl_q.wb_sel;
    assign out_func3     = ctrl_q.func3;
    assign out_func1     = ctrl_q.func1;
    assign out_func_mem  = ctrl_q.func_mem;
    assign out_reg_write = ctrl_q.reg_write;
    assign out_is_branch = ctrl_q.is_branch;
    assign out_is_jal    = ctrl_q.is_jal;
    assign out_is_jalr   = ctrl_q.is_jalr;
    assign out_is_load   = ctrl_q.is_load;
    assign out_is_store  = ctrl_q.is_store;
    assign out_illegal   = ctrl_q.illegal;
    assign out_muldiv    = ctrl_q.muldiv;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: two instances (stall depth 1 and 3) driven by shared stimulus,
// checked every cycle against a behavioural model plus directed literal expectations.
module tb_decode_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        rdy [2];
    logic        ov [2];
    logic [31:0] opc [2];
    logic [4:0]  ors1 [2], ors2 [2], ord [2];
    logic [1:0]  os1 [2], os2 [2], owb [2];
    logic [2:0]  of3 [2], ofm [2];
    logic [0:0]  of1 [2];
    logic        orw [2], obr [2], ojal [2], ojalr [2], old [2], ost [2], oill [2], omd [2];

    always #5 clk = ~clk;

    decode_ctrl_stage #(.XLEN(32), .LOAD_STALL_CYCLES(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_instr(in_instr),
        .in_pc(in_pc), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready), .out_pc(opc[0]),
        .out_rs1(ors1[0]), .out_rs2(ors2[0]), .out_rd(ord[0]), .out_rs1_sel(os1[0]),
        .out_rs2_sel(os2[0]), .out_wb_sel(owb[0]), .out_func3(of3[0]), .out_func1(of1[0]),
        .out_func_mem(ofm[0]), .out_reg_write(orw[0]), .out_is_branch(obr[0]), .out_is_jal(ojal[0]),
        .out_is_jalr(ojalr[0]), .out_is_load(old[0]), .out_is_store(ost[0]), .out_illegal(oill[0]),
        .out_muldiv(omd[0]));

    decode_ctrl_stage #(.XLEN(32), .LOAD_STALL_CYCLES(3)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_instr(in_instr),
        .in_pc(in_pc), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready), .out_pc(opc[1]),
        .out_rs1(ors1[1]), .out_rs2(ors2[1]), .out_rd(ord[1]), .out_rs1_sel(os1[1]),
        .out_rs2_sel(os2[1]), .out_wb_sel(owb[1]), .out_func3(of3[1]), .out_func1(of1[1]),
        .out_func_mem(ofm[1]), .out_reg_write(orw[1]), .out_is_branch(obr[1]), .out_is_jal(ojal[1]),
        .out_is_jalr(ojalr[1]), .out_is_load(old[1]), .out_is_store(ost[1]), .out_illegal(oill[1]),
        .out_muldiv(omd[1]));

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [1:0]  s1, s2, wb;
        logic [2:0]  f3;
        logic        f1;
        logic [2:0]  fm;
        logic        rw, br, jal, jalr, ld, st, ill, md;
    } cw_t;

    // Reference model state
    cw_t        m_cw [2];
    logic       m_v [2];
    int         m_stall [2];
    logic [4:0] m_ldrd [2];
    logic       m_rdy [2];

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] I_ADDI1 = 32'h00510093;  // addi x1,x2,5
    localparam logic [31:0] I_LW5   = 32'h0000A283;  // lw x5,0(x1)
    localparam logic [31:0] I_ADD6  = 32'h00528333;  // add x6,x5,x5
    localparam logic [31:0] I_ADDI7 = 32'h00140393;  // addi x7,x8,1
    localparam logic [31:0] I_MUL   = 32'h022081B3;  // mul x3,x1,x2
    localparam logic [31:0] I_BAD   = 32'h0000007F;

    function automatic int lsc(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic cw_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        cw_t c;
        logic [2:0] f3;
        c = '0;
        f3 = ins[14:12];
        c.pc = pc; c.rs1 = ins[19:15]; c.rs2 = ins[24:20]; c.rd = ins[11:7];
        case (ins[6:0])
            7'h37: begin c.wb = 2'd3; c.rw = 1'b1; end
            7'h17: begin c.wb = 2'd1; c.rw = 1'b1; end
            7'h6F: begin c.jal = 1'b1; c.rw = 1'b1; end
            7'h67: begin c.jalr = 1'b1; c.s1 = 2'd1; c.s2 = 2'd2; c.rw = 1'b1; end
            7'h63: begin c.br = 1'b1; c.f3 = f3; end
            7'h23: begin c.st = 1'b1; c.s1 = 2'd1; c.s2 = 2'd1; c.fm = f3; end
            7'h03: begin c.ld = 1'b1; c.s1 = 2'd1; c.s2 = 2'd2; c.wb = 2'd2; c.fm = f3; c.rw = 1'b1; end
            7'h33: begin
                if (ins[31:25] == 7'd1) begin
`ifdef DECODE_MULDIV_EN
                    c.md = 1'b1; c.s1 = 2'd1; c.s2 = 2'd3; c.f3 = f3; c.wb = 2'd1; c.rw = 1'b1;
`else
                    c.ill = 1'b1;
`endif
                end else begin
                    c.s1 = 2'd1; c.s2 = 2'd3; c.f3 = f3; c.f1 = ins[30]; c.wb = 2'd1; c.rw = 1'b1;
                end
            end
            7'h13: begin
                c.s1 = 2'd1; c.s2 = 2'd2; c.f3 = f3; c.wb = 2'd1; c.rw = 1'b1;
                c.f1 = (f3 == 3'd5) ? ins[30] : 1'b0;
            end
            default: c.ill = 1'b1;
        endcase
        if (c.rd == 5'd0) c.rw = 1'b0;
        return c;
    endfunction

    // Returns {reads rs2, reads rs1}
    function automatic logic [1:0] ref_uses(input logic [31:0] ins);
        case (ins[6:0])
            7'h67, 7'h03, 7'h13: return 2'b01;
            7'h63, 7'h23, 7'h33: return 2'b11;
            default:             return 2'b00;
        endcase
    endfunction

    function automatic cw_t got(input int k);
        cw_t g;
        g.pc = opc[k]; g.rs1 = ors1[k]; g.rs2 = ors2[k]; g.rd = ord[k];
        g.s1 = os1[k]; g.s2 = os2[k]; g.wb = owb[k]; g.f3 = of3[k]; g.f1 = of1[k][0];
        g.fm = ofm[k]; g.rw = orw[k]; g.br = obr[k]; g.jal = ojal[k]; g.jalr = ojalr[k];
        g.ld = old[k]; g.st = ost[k]; g.ill = oill[k]; g.md = omd[k];
        return g;
    endfunction

    task automatic chk(input string nm, input int k, input logic [127:0] g, input logic [127:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got=%0h expected=%0h", nm, k, $time, g, e);
        end
    endtask

    // One cycle: drive inputs, compare both DUTs to the model, then advance the model.
    task automatic step(input logic r, input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic ordy);
        logic [1:0] u;
        logic       haz, iss, acc;
        @(posedge clk);
        #1;
        rst = r; in_valid = v; in_instr = ins; in_pc = pc; flush = fl; out_ready = ordy;
        @(negedge clk);
        u = ref_uses(ins);
        for (int k = 0; k < 2; k++) begin
            haz = (m_stall[k] > 0) && v &&
                  ((u[0] && (ins[19:15] == m_ldrd[k])) || (u[1] && (ins[24:20] == m_ldrd[k])));
            m_rdy[k] = !r && !fl && !haz && (!m_v[k] || ordy);
            chk("out_valid", k, 128'(ov[k]), 128'(m_v[k]));
            if (m_v[k]) chk("ctrl_word", k, 128'(got(k)), 128'(m_cw[k]));
            chk("in_ready", k, 128'(rdy[k]), 128'(m_rdy[k]));
            if (r) begin
                m_v[k] = 1'b0; m_cw[k] = '0; m_stall[k] = 0;
            end else if (fl) begin
                m_v[k] = 1'b0; m_stall[k] = 0;
            end else begin
                iss = m_v[k] && ordy;
                acc = v && m_rdy[k];
                if (iss && m_cw[k].ld && (m_cw[k].rd != 5'd0)) begin
                    m_stall[k] = lsc(k); m_ldrd[k] = m_cw[k].rd;
                end else if (m_stall[k] > 0) begin
                    m_stall[k] = m_stall[k] - 1;
                end
                if (acc) begin
                    m_cw[k] = ref_decode(ins, pc); m_v[k] = 1'b1;
                end else if (iss) begin
                    m_v[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  ops [11];
        int          sel;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h23, 7'h03, 7'h03, 7'h33, 7'h13, 7'h7F};
        ins = $urandom();
        sel = $urandom_range(0, 10);
        ins[6:0]   = ops[sel];
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        if (ops[sel] == 7'h33) begin
            case ($urandom_range(0, 2))
                0:       ins[31:25] = 7'b0000000;
                1:       ins[31:25] = 7'b0100000;
                default: ins[31:25] = 7'b0000001;
            endcase
        end
        return ins;
    endfunction

    int hold [2];
    logic done [2];

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0; flush = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_v[k] = 1'b0; m_cw[k] = '0; m_stall[k] = 0; m_ldrd[k] = 5'd0; m_rdy[k] = 1'b0;
        end
        repeat (2) @(posedge clk);

        // Reset cycle
        step(1'b1, 1'b1, I_ADDI1, 32'h0, 1'b0, 1'b1);
        chk("reset_in_ready", 0, 128'(rdy[0]), 128'(1'b0));
        chk("reset_out_valid", 1, 128'(ov[1]), 128'(1'b0));

        // ADDI x1,x2,5
        step(1'b0, 1'b1, I_ADDI1, 32'h100, 1'b0, 1'b1);
        idle(1);
        chk("addi_valid", 0, 128'(ov[0]), 128'(1'b1));
        chk("addi_sels", 0, 128'({os1[0], os2[0], owb[0]}), 128'(6'b01_10_01));
        chk("addi_f3_rd_rw", 0, 128'({of3[0], ord[0], orw[0]}), 128'({3'd0, 5'd1, 1'b1}));

        // LW x5 issues, then dependent ADD is held LOAD_STALL_CYCLES cycles
        step(1'b0, 1'b1, I_LW5, 32'h104, 1'b0, 1'b1);
        idle(1);
        hold = '{0, 0}; done = '{1'b0, 1'b0};
        for (int i = 0; i < 10 && !(done[0] && done[1]); i++) begin
            step(1'b0, 1'b1, I_ADD6, 32'h108, 1'b0, 1'b1);
            for (int k = 0; k < 2; k++) begin
                if (!done[k]) begin
                    if (rdy[k]) done[k] = 1'b1;
                    else hold[k]++;
                end
            end
        end
        chk("ldu_hold_1", 0, 128'(hold[0]), 128'(1));
        chk("ldu_hold_3", 1, 128'(hold[1]), 128'(3));
        idle(1);
        chk("add_rs2_sel", 1, 128'(os2[1]), 128'(2'b11));
        idle(4);

        // LW x5 then independent ADDI x7,x8,1: back-to-back, and no bubble in STALL
        step(1'b0, 1'b1, I_LW5, 32'h110, 1'b0, 1'b1);
        step(1'b0, 1'b1, I_ADDI7, 32'h114, 1'b0, 1'b1);
        chk("b2b_lw_valid", 0, 128'(ov[0]), 128'(1'b1));
        step(1'b0, 1'b1, I_ADDI7, 32'h118, 1'b0, 1'b1);
        chk("indep_in_stall_ready", 1, 128'(rdy[1]), 128'(1'b1));
        chk("b2b_addi", 1, 128'({ov[1], ord[1], opc[1]}), 128'({1'b1, 5'd7, 32'h114}));
        idle(4);

        // Back-pressure: held word stable, in_ready low
        step(1'b0, 1'b1, I_ADDI7, 32'h200, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, I_ADDI1, 32'h204, 1'b0, 1'b0);
            chk("bp_ready_low", 0, 128'(rdy[0]), 128'(1'b0));
            chk("bp_word_stable", 1, 128'({ov[1], opc[1]}), 128'({1'b1, 32'h200}));
        end
        step(1'b0, 1'b1, I_ADDI1, 32'h204, 1'b0, 1'b1);
        chk("bp_release_ready", 0, 128'(rdy[0]), 128'(1'b1));
        idle(1);
        chk("bp_next_word", 0, 128'({ov[0], opc[0]}), 128'({1'b1, 32'h204}));
        idle(4);

        // Flush during STALL with a dependent ADD pending
        step(1'b0, 1'b1, I_LW5, 32'h300, 1'b0, 1'b1);
        idle(1);
        step(1'b0, 1'b1, I_ADD6, 32'h304, 1'b1, 1'b1);
        chk("flush_ready", 1, 128'(rdy[1]), 128'(1'b0));
        step(1'b0, 1'b1, I_ADD6, 32'h304, 1'b0, 1'b1);
        chk("flush_valid_low", 1, 128'(ov[1]), 128'(1'b0));
        chk("flush_then_accept", 1, 128'(rdy[1]), 128'(1'b1));
        idle(1);
        chk("flush_dep_out", 1, 128'({ov[1], opc[1]}), 128'({1'b1, 32'h304}));
        idle(4);

        // MUL and unknown opcode
        step(1'b0, 1'b1, I_MUL, 32'h400, 1'b0, 1'b1);
        idle(1);
`ifdef DECODE_MULDIV_EN
        chk("mul_decode", 0, 128'({omd[0], oill[0], orw[0]}), 128'(3'b101));
`else
        chk("mul_illegal", 0, 128'({omd[0], oill[0], orw[0]}), 128'(3'b010));
`endif
        step(1'b0, 1'b1, I_BAD, 32'h404, 1'b0, 1'b1);
        idle(1);
        chk("bad_opcode", 1, 128'({oill[1], orw[1], owb[1]}), 128'({1'b1, 1'b0, 2'b00}));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), rand_instr(), $urandom(),
                 ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 8));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_stage.md
# decode_ctrl_stage

Registered, parametrised ID-stage control decoder for the RV32I core. It accepts one instruction per cycle over a valid/ready handshake and emits a registered control word (ALU operand selects, writeback select, func codes, memory func, branch/jump flags) to the EX stage. It adds load-use interlocking, pipeline flush and illegal-opcode flagging. Ports follow the existing control-word encodings, so the EX, memory and writeback datapath is unchanged.

## Interface
- XLEN, 32: width of the PC path.
- LOAD_STALL_CYCLES, 1: cycles a dependent instruction is held after a load issues; legal 1..3.
- clk in 1: clock, rising edge.
- rst in 1: synchronous, active-high reset.
- in_valid in 1: upstream instruction valid.
- in_ready out 1: stage can accept; combinational.
- in_instr in 32: instruction word.
- in_pc in XLEN: instruction PC.
- flush in 1: kill the held word and any pending interlock (branch mispredict or trap).
- out_valid out 1: control word valid.
- out_ready in 1: EX stage accepts.
- out_pc out XLEN: registered PC.
- out_rs1, out_rs2, out_rd out 5 each: register indices.
- out_rs1_sel, out_rs2_sel out 2 each:
  - rs1: 00 = PC, 01 = rs1.
  - rs2: 00 = none, 01 = S-imm, 10 = I-imm, 11 = rs2.
- out_wb_sel out 2: 00 = PC+4, 01 = ALU, 10 = memory, 11 = U-imm.
- out_func3 out 3, out_func1 out 1: ALU function code.
- out_func_mem out 3: memory access width and sign.
- out_reg_write out 1: writeback enable.
- out_is_branch, out_is_jal, out_is_jalr, out_is_load, out_is_store out 1 each.
- out_illegal out 1: unrecognised opcode.
- out_muldiv out 1: M-extension op (see Configuration).

## Operation
- Decode per opcode, using the same selects as the single-cycle control unit:
  - LUI: wb 11.
  - AUIPC: rs1 00, ALU add, wb 01.
  - JAL: is_jal, wb 00.
  - JALR: rs1 01, rs2 10, add, wb 00.
  - BRANCH: func3 = instr[14:12], no write.
  - STORE: rs1 01, rs2 01, add, func_mem = instr[14:12].
  - LOAD: rs1 01, rs2 10, add, wb 10, func_mem = instr[14:12].
  - R-type: rs1 01, rs2 11, func3 = instr[14:12], func1 = instr[30], wb 01.
  - I-type: rs1 01, rs2 10, wb 01; func1 = instr[30] only when func3 = 101, else 0.
- out_reg_write is forced 0 when rd = 0.
- Unknown opcode: out_illegal = 1, all other controls 0, out_valid still asserted so the trap logic sees the word.
- Register use:
  - rs1 is read by JALR, BRANCH, LOAD, STORE, R and I types.
  - rs2 is read by BRANCH, STORE and R types.
- Interlock FSM has two states, RUN and STALL.
  - Issue event (out_valid && out_ready): if the issued word is a load with rd ≠ 0, record ld_rd, load cnt = LOAD_STALL_CYCLES and enter STALL.
  - In STALL, cnt decrements every cycle.
  - When cnt reaches 1 and decrements to 0, the FSM returns to RUN on the same edge, unless a new load issues on that edge. A new load reloads cnt and ld_rd.
- hazard = STALL && in_valid && the instruction reads ld_rd through a used rs1 or rs2.
- in_ready = !rst && !flush && !hazard && (!out_valid || out_ready).
- Accept (in_valid && in_ready): the output register loads the decoded word; out_valid = 1.
- Issue without a new accept: out_valid clears to 0.
- flush: out_valid = 0, FSM goes to RUN, cnt = 0; no accept that cycle. flush overrides a simultaneous accept and a simultaneous load issue.
- Reset: every output register is 0, FSM is RUN, cnt = 0, and in_ready is 0 during the reset cycle.

## Timing
- Latency is 1 cycle from accept edge to out_valid.
- Throughput is 1 per cycle with no hazard and out_ready held high.
- With out_ready low, the held word is stable and in_ready is 0 while out_valid = 1.
- A dependent instruction is held for exactly LOAD_STALL_CYCLES cycles after the load's issue edge. It is accepted on the first cycle with cnt = 0.
- Independent instructions pass during STALL without a bubble.
- A reset asserted mid-stall clears the interlock on that edge.

## Configuration
- DECODE_MULDIV_EN defined:
  - R-type with instr[31:25] = 0000001 decodes with out_muldiv = 1, func3 = instr[14:12], func1 = 0, wb 01, rs2 sel 11.
- DECODE_MULDIV_EN undefined:
  - Such words set out_illegal = 1 with all other controls 0.
  - out_muldiv is tied to 0.

## Test plan
- Reset, then ADDI x1,x2,5 (0x00510093) with out_ready = 1: out_valid one cycle later; rs1_sel 01, rs2_sel 10, wb 01, func3 000, rd 1, reg_write 1.
- LW x5,0(x1) (0x0000A283) then ADD x6,x5,x5 (0x00528333), LOAD_STALL_CYCLES = 1:
  - ADD is held (in_ready = 0) for exactly 1 cycle after LW issues, then decoded with rs2_sel 11.
  - Repeat with LOAD_STALL_CYCLES = 3: the hold is 3 cycles.
- LW x5 followed by ADDI x7,x8,1: no stall, back-to-back out_valid.
- out_ready held 0 for 4 cycles with in_valid = 1: the output word is stable and in_ready = 0; on release, the next word follows the next cycle.
- flush during STALL with an accept pending: out_valid = 0 next cycle, and the dependent instruction is accepted the cycle after flush deasserts.
- MUL x3,x1,x2 (0x022081B3):
  - With DECODE_MULDIV_EN: out_muldiv = 1, out_illegal = 0.
  - Without it: out_illegal = 1, reg_write = 0.
  - Opcode 0x7F gives out_illegal = 1 in both builds.
